// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : counter_seq_ctrl
// Brief   : Command sequencer driving an up/down preloadable counter with
//           exact cycle timing. Optional SEQ_WRAP_STOP_EN ends RUN on wrap.
// Rev     : 1.0
// ============================================================================

module counter_seq_ctrl #(
   parameter int ARG_W    = 16,
   parameter int DATA_W   = 4,
   parameter int CNT_W    = 8,
   parameter bit IDLE_RUN = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   input  logic [2:0]        cmd_op,
   input  logic [ARG_W-1:0]  cmd_arg,
   output logic              cmd_ready,
   input  logic              abort,
   input  logic [CNT_W-1:0]  cnt_value,
   output logic              cnt_enable,
   output logic              cnt_updn,
   output logic              cnt_preload,
   output logic [DATA_W-1:0] cnt_pl_data,
   output logic [DATA_W-1:0] cnt_incr,
   output logic              done,
   output logic              err
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PRELOAD = 2'd1;
   localparam logic [1:0] S_RUN     = 2'd2;
   localparam logic [1:0] S_PAUSE   = 2'd3;

   localparam logic [2:0] OP_NOP      = 3'd0;
   localparam logic [2:0] OP_PRELOAD  = 3'd1;
   localparam logic [2:0] OP_RUN      = 3'd2;
   localparam logic [2:0] OP_PAUSE    = 3'd3;
   localparam logic [2:0] OP_SET_INCR = 3'd4;
   localparam logic [2:0] OP_SET_DIR  = 3'd5;

   localparam logic [ARG_W-1:0]  ARG_ONE  = {{(ARG_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] INCR_RST = {{(DATA_W-1){1'b0}}, 1'b1};

   logic [1:0]        state_q, state_d;
   logic [ARG_W-1:0]  rem_q, rem_d;
   logic              enable_q, enable_d;
   logic              updn_q, updn_d;
   logic              preload_q, preload_d;
   logic [DATA_W-1:0] pl_data_q, pl_data_d;
   logic [DATA_W-1:0] incr_q, incr_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic accept;
   logic arg_zero;
   logic finish;
   logic finish_ok;
   logic wrap_hit;

   assign cmd_ready = (state_q == S_IDLE) & ~reset;
   assign accept    = cmd_valid & cmd_ready;
   assign arg_zero  = (cmd_arg == '0);

`ifdef SEQ_WRAP_STOP_EN
   // Previous-cycle sample of the counter; valid only from the second RUN cycle on.
   logic [CNT_W-1:0] prev_value_q, prev_value_d;
   logic             prev_valid_q, prev_valid_d;

   assign prev_value_d = cnt_value;
   assign prev_valid_d = (state_q == S_RUN) && (state_d == S_RUN);
   assign wrap_hit     = prev_valid_q && (state_q == S_RUN) &&
                         (updn_q ? ((prev_value_q == {CNT_W{1'b1}}) && (cnt_value < prev_value_q))
                                 : ((prev_value_q == '0) && (cnt_value > prev_value_q)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_value_q <= '0;
         prev_valid_q <= 1'b0;
      end else begin
         prev_value_q <= prev_value_d;
         prev_valid_q <= prev_valid_d;
      end
   end
`else
   logic unused_cnt_value;
   assign unused_cnt_value = ^cnt_value;
   assign wrap_hit         = 1'b0;
`endif

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rem_q     <= '0;
         enable_q  <= IDLE_RUN;
         updn_q    <= 1'b1;
         preload_q <= 1'b0;
         pl_data_q <= '0;
         incr_q    <= INCR_RST;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         enable_q  <= enable_d;
         updn_q    <= updn_d;
         preload_q <= preload_d;
         pl_data_q <= pl_data_d;
         incr_q    <= incr_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next state; abort takes priority over a normal completion in the same cycle
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      finish    = 1'b0;
      finish_ok = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_PRELOAD: state_d = S_PRELOAD;
                  OP_RUN: begin
                     if (!arg_zero) begin
                        state_d = S_RUN;
                        rem_d   = cmd_arg;
                     end
                  end
                  OP_PAUSE: begin
                     if (!arg_zero) begin
                        state_d = S_PAUSE;
                        rem_d   = cmd_arg;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: begin
            if (abort) begin
               finish = 1'b1;
            end else if ((state_q == S_PRELOAD) || (rem_q == ARG_ONE) || wrap_hit) begin
               finish    = 1'b1;
               finish_ok = 1'b1;
            end else begin
               rem_d = rem_q - ARG_ONE;
            end
            if (finish) begin
               state_d = S_IDLE;
               rem_d   = '0;
            end
         end
      endcase
   end

   // Next values of the registered counter-control outputs
   always_comb begin
      enable_d  = enable_q;
      updn_d    = updn_q;
      preload_d = 1'b0;
      pl_data_d = pl_data_q;
      incr_d    = incr_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      if (state_q == S_IDLE) begin
         if (accept) begin
            case (cmd_op)
               OP_NOP: done_d = 1'b1;
               OP_PRELOAD: begin
                  pl_data_d = cmd_arg[DATA_W-1:0];
                  preload_d = 1'b1;
                  enable_d  = 1'b0;
               end
               OP_RUN: begin
                  if (arg_zero) done_d   = 1'b1;
                  else          enable_d = 1'b1;
               end
               OP_PAUSE: begin
                  if (arg_zero) done_d   = 1'b1;
                  else          enable_d = 1'b0;
               end
               OP_SET_INCR: begin
                  incr_d = cmd_arg[DATA_W-1:0];
                  done_d = 1'b1;
               end
               OP_SET_DIR: begin
                  updn_d = cmd_arg[0];
                  done_d = 1'b1;
               end
               default: err_d = 1'b1;
            endcase
         end
      end else if (finish) begin
         enable_d = IDLE_RUN;
         done_d   = finish_ok;
      end
   end

   assign cnt_enable  = enable_q;
   assign cnt_updn    = updn_q;
   assign cnt_preload = preload_q;
   assign cnt_pl_data = pl_data_q;
   assign cnt_incr    = incr_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

`default_nettype wire
